instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 168 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with a data-memory timeout.
// Optional busy-cycle counter enabled by defining CYCLE_COUNT_EN; otherwise CYCLE_COUNT reads 0.
module instr_sequencer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic        REG_WRITE,
    input  logic        BRANCH,
    input  logic        HALT,
    input  logic        DMEM_ACK,
    output logic        IR_EN,
    output logic        PC_EN,
    output logic        REG_WE,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic        DONE,
    output logic        FAULT,
    output logic [2:0]  STATE,
    output logic [15:0] CYCLE_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    // Last no-ack MEM cycle allowed; reaching it without ack is a timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state;
    state_t     state_next;
    logic       lat_rd;
    logic       lat_wr;
    logic       lat_rw;
    logic       lat_halt;
    logic [7:0] wait_cnt;

    // BRANCH is observational only, and the halt decision is taken from the live line in DECODE.
    logic unused_ok;
    assign unused_ok = ^{BRANCH, lat_halt};

    assign STATE = state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lat_rd   <= 1'b0;
            lat_wr   <= 1'b0;
            lat_rw   <= 1'b0;
            lat_halt <= 1'b0;
        end else if (state == S_DECODE) begin
            lat_rd   <= MEM_READ;
            lat_wr   <= MEM_WRITE;
            lat_rw   <= REG_WRITE;
            lat_halt <= HALT;
        end
    end

    // Counts consecutive no-ack MEM cycles; zero whenever MEM is entered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt <= 8'd0;
        end else if (state != S_MEM) begin
            wait_cnt <= 8'd0;
        end else if (!DMEM_ACK) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        IR_EN      = 1'b0;
        PC_EN      = 1'b0;
        REG_WE     = 1'b0;
        DMEM_REQ   = 1'b0;
        DMEM_WE    = 1'b0;
        DONE       = 1'b0;
        FAULT      = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) state_next = S_FETCH;
            end
            S_FETCH: begin
                IR_EN      = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                state_next = HALT ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                if (lat_rd || lat_wr) begin
                    state_next = S_MEM;
                end else if (lat_rw) begin
                    state_next = S_WB;
                end else begin
                    PC_EN      = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                // Read wins when both read and write are latched.
                DMEM_REQ = 1'b1;
                DMEM_WE  = lat_wr && !lat_rd;
                if (DMEM_ACK) begin
                    if (lat_rd) begin
                        state_next = S_WB;
                    end else begin
                        PC_EN      = 1'b1;
                        state_next = S_FETCH;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_FAULT;
                end
            end
            S_WB: begin
                REG_WE     = 1'b1;
                PC_EN      = 1'b1;
                state_next = S_FETCH;
            end
            S_HALTED: begin
                DONE = 1'b1;
                if (START) state_next = S_FETCH;
            end
            S_FAULT: begin
                DONE  = 1'b1;
                FAULT = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef CYCLE_COUNT_EN
    logic [15:0] cycle_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cycle_cnt <= 16'd0;
        end else if ((state == S_IDLE || state == S_HALTED) && START) begin
            cycle_cnt <= 16'd0;
        end else if ((state inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB})
                     && (cycle_cnt != 16'hFFFF)) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign CYCLE_COUNT = cycle_cnt;
`else
    assign CYCLE_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instructions are expanded into expected per-cycle state/output
// records from their kind and ack delay, then replayed against the DUT cycle by cycle.
module tb_instr_sequencer;

    localparam int WAIT_MAX = 4;

    localparam logic [6:0] O_IR   = 7'b1000000;
    localparam logic [6:0] O_PC   = 7'b0100000;
    localparam logic [6:0] O_RWE  = 7'b0010000;
    localparam logic [6:0] O_REQ  = 7'b0001000;
    localparam logic [6:0] O_WE   = 7'b0000100;
    localparam logic [6:0] O_DONE = 7'b0000010;
    localparam logic [6:0] O_FLT  = 7'b0000001;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic        REG_WRITE;
    logic        BRANCH;
    logic        HALT;
    logic        DMEM_ACK;
    logic        IR_EN;
    logic        PC_EN;
    logic        REG_WE;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic        DONE;
    logic        FAULT;
    logic [2:0]  STATE;
    logic [15:0] CYCLE_COUNT;

    instr_sequencer #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .MEM_READ    (MEM_READ),
        .MEM_WRITE   (MEM_WRITE),
        .REG_WRITE   (REG_WRITE),
        .BRANCH      (BRANCH),
        .HALT        (HALT),
        .DMEM_ACK    (DMEM_ACK),
        .IR_EN       (IR_EN),
        .PC_EN       (PC_EN),
        .REG_WE      (REG_WE),
        .DMEM_REQ    (DMEM_REQ),
        .DMEM_WE     (DMEM_WE),
        .DONE        (DONE),
        .FAULT       (FAULT),
        .STATE       (STATE),
        .CYCLE_COUNT (CYCLE_COUNT)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // stim: {start, ack, mem_read, mem_write, reg_write, branch, halt}
    logic [6:0]  stim_q[$];
    // exp:  {state, ir_en, pc_en, reg_we, dmem_req, dmem_we, done, fault}
    logic [9:0]  exp_q[$];
    logic [15:0] cc_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] junk();
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [6:0] outs_now();
        return {IR_EN, PC_EN, REG_WE, DMEM_REQ, DMEM_WE, DONE, FAULT};
    endfunction

    task automatic push(input logic [2:0] st, input logic [6:0] outs,
                        input logic start, input logic ack, input logic [4:0] dec);
        stim_q.push_back({start, ack, dec});
        exp_q.push_back({st, outs});
    endtask

    // Expand one instruction (dec = {mem_read, mem_write, reg_write, branch, halt}) whose
    // data access is acknowledged on MEM cycle d (d >= WAIT_MAX means never).
    // rest: 0 idle, 6 halted, 1 next cycle fetches, 7 faulted.
    task automatic gen_instr(inout int rest, input logic [4:0] dec, input int d);
        logic       mr, mw, rw, hl;
        logic [6:0] memo;
        int         nk;
        mr = dec[4];
        mw = dec[3];
        rw = dec[2];
        hl = dec[0];
        if (rest == 0 || rest == 6) begin
            nk = $urandom_range(0, 2);
            for (int k = 0; k < nk; k++)
                push(3'(rest), (rest == 6) ? O_DONE : 7'd0, 1'b0, rb(), junk());
            push(3'(rest), (rest == 6) ? O_DONE : 7'd0, 1'b1, rb(), junk());
        end
        push(3'd1, O_IR, rb(), rb(), junk());
        push(3'd2, 7'd0, rb(), rb(), dec);
        if (hl) begin
            rest = 6;
            return;
        end
        rest = 1;
        if (mr || mw) begin
            push(3'd3, 7'd0, rb(), rb(), junk());
            memo = O_REQ | ((mw && !mr) ? O_WE : 7'd0);
            for (int i = 0; i < WAIT_MAX; i++) begin
                if (i == d) begin
                    push(3'd4, memo | (mr ? 7'd0 : O_PC), rb(), 1'b1, junk());
                    if (mr) push(3'd5, O_RWE | O_PC, rb(), rb(), junk());
                    return;
                end
                push(3'd4, memo, rb(), 1'b0, junk());
            end
            rest = 7;
            for (int k = 0; k < 3; k++)
                push(3'd7, O_DONE | O_FLT, rb(), rb(), junk());
        end else if (rw) begin
            push(3'd3, 7'd0, rb(), rb(), junk());
            push(3'd5, O_RWE | O_PC, rb(), rb(), junk());
        end else begin
            push(3'd3, O_PC, rb(), rb(), junk());
        end
    endtask

    function automatic logic [15:0] cc_exp();
`ifdef CYCLE_COUNT_EN
        return cc_model;
`else
        return 16'd0;
`endif
    endfunction

    // Called at posedge+1; leaves at posedge+1.
    task automatic play();
        logic [6:0] s;
        logic [9:0] e;
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            {START, DMEM_ACK, MEM_READ, MEM_WRITE, REG_WRITE, BRANCH, HALT} = s;
            #2;
            check("state", 32'(STATE), 32'(e[9:7]));
            check("outputs", 32'(outs_now()), 32'(e[6:0]));
            check("cycle_count", 32'(CYCLE_COUNT), 32'(cc_exp()));
            if (e[9:7] >= 3'd1 && e[9:7] <= 3'd5) begin
                if (cc_model != 16'hFFFF) cc_model = cc_model + 16'd1;
            end else if ((e[9:7] == 3'd0 || e[9:7] == 3'd6) && s[6]) begin
                cc_model = 16'd0;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        {START, DMEM_ACK, MEM_READ, MEM_WRITE, REG_WRITE, BRANCH, HALT} = 7'd0;
        #1;
        check("reset_state", 32'(STATE), 32'd0);
        check("reset_outputs", 32'(outs_now()), 32'd0);
        check("reset_cycle_count", 32'(CYCLE_COUNT), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cc_model = 16'd0;
    endtask

    initial begin
        int         rest;
        logic [4:0] dec;
        int         d;
        int         n;
        RESET = 1'b1;
        {START, DMEM_ACK, MEM_READ, MEM_WRITE, REG_WRITE, BRANCH, HALT} = 7'd0;
        cc_model = 16'd0;
        @(posedge CLK);
        #1;

        // Directed: ALU, load with 3 waits, store with immediate ack, halt then resume.
        do_reset();
        rest = 0;
        gen_instr(rest, 5'b00100, 0);
        gen_instr(rest, 5'b10000, 3);
        gen_instr(rest, 5'b01000, 0);
        gen_instr(rest, 5'b11000, 1);
        gen_instr(rest, 5'b00011, 0);
        gen_instr(rest, 5'b00010, 0);
        play();

        // Directed: never-acknowledged store faults and ignores START.
        do_reset();
        rest = 0;
        gen_instr(rest, 5'b01000, WAIT_MAX);
        play();

        // Directed: reset while a read is waiting in MEM.
        do_reset();
        push(3'd0, 7'd0, 1'b1, 1'b0, 5'd0);
        push(3'd1, O_IR, 1'b0, 1'b0, 5'd0);
        push(3'd2, 7'd0, 1'b0, 1'b0, 5'b10000);
        push(3'd3, 7'd0, 1'b0, 1'b0, 5'd0);
        push(3'd4, O_REQ, 1'b0, 1'b0, 5'd0);
        push(3'd4, O_REQ, 1'b0, 1'b0, 5'd0);
        play();
        DMEM_ACK = 1'b0;
        #1;
        check("pre_reset_req", 32'({STATE, DMEM_REQ}), 32'({3'd4, 1'b1}));
        RESET = 1'b1;
        #1;
        check("mid_mem_reset_state", 32'(STATE), 32'd0);
        check("mid_mem_reset_outputs", 32'(outs_now()), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cc_model = 16'd0;
        rest = 0;
        gen_instr(rest, 5'b00100, 0);
        play();

        // Random programs.
        for (int p = 0; p < 30; p++) begin
            do_reset();
            rest = 0;
            n = 0;
            while (n < 15 && rest != 7) begin
                dec = junk();
                dec[0] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 9) == 0) d = $urandom_range(WAIT_MAX, WAIT_MAX + 1);
                else d = $urandom_range(0, WAIT_MAX - 1);
                gen_instr(rest, dec, d);
                n++;
            end
            play();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
